dino_game_ctrl: RTL and testbench



---
 rtl/dino_pkg.sv | 23 ++
 rtl/dino_bcd_counter.sv | 49 ++++
 rtl/dino_game_ctrl.sv | 147 ++++++++++++++
 tb/tb_dino_game_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the Dino Run game-flow sequencer.
package dino_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RESTART = 3'd1,
      RUN     = 3'd2,
      DYING   = 3'd3,
      OVER    = 3'd4
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [5:0]  LFSR_SEED     = 6'b101011;
   localparam int          NUM_OBSTACLES = 4;
   localparam logic [19:0] SCORE_MAX     = 20'h99999;

   // One step of the 6-bit respawn-offset LFSR.
   function automatic logic [5:0] lfsr_next(input logic [5:0] r);
      return {r[4:0], r[5] ^ r[4]};
   endfunction

endpackage

// File: rtl/dino_bcd_counter.sv
// Five-digit BCD score counter: synchronous clear, increment enable,
// saturates at 99999 instead of wrapping.
module dino_bcd_counter
   import dino_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        inc,
   output logic [19:0] bcd_o
);

   logic [19:0] bcd_q;
   logic [19:0] bcd_d;
   logic        carry;
   bcd_digit_t  dig;

   // Ripple a +1 through the digits, each 9 rolling to 0 and carrying on.
   always_comb begin
      bcd_d = bcd_q;
      carry = 1'b1;
      dig   = '0;
      for (int i = 0; i < 5; i++) begin
         dig = bcd_q[i*4 +: 4];
         if (carry) begin
            if (dig == 4'd9) begin
               bcd_d[i*4 +: 4] = 4'd0;
            end else begin
               bcd_d[i*4 +: 4] = dig + 4'd1;
               carry           = 1'b0;
            end
         end
      end
   end

   // Score register; 99999 is held rather than wrapped to 00000.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcd_q <= '0;
      end else if (clr) begin
         bcd_q <= '0;
      end else if (inc && (bcd_q != SCORE_MAX)) begin
         bcd_q <= bcd_d;
      end
   end

   assign bcd_o = bcd_q;

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino Run game-flow sequencer: game FSM, motion tick divider, speed
// schedule, score counter and respawn LFSR.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start press; LFSR free-runs to seed randomness
// RESTART | single cycle: reload obstacles, clear score/speed/phase
// RUN     | game in play; motion ticks advance obstacles and score
// DYING   | freeze after collision for DYING_TICKS divider periods
// OVER    | replay overlay shown; waiting for press
module dino_game_ctrl
   import dino_pkg::*;
#(
   parameter int TICK_DIV         = 2_000_000,
   parameter int SPEED_INIT       = 1,
   parameter int SPEED_MAX        = 8,
   parameter int PASSES_PER_LEVEL = 12,
   parameter int DYING_TICKS      = 32
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     collision_i,
   input  logic [NUM_OBSTACLES-1:0] wrap_i,
   input  logic                     btn_i,
   output logic [2:0]               state_o,
   output logic                     motion_tick_o,
   output logic [10:0]              speed_o,
   output logic                     reload_o,
   output logic [1:0]               anim_phase_o,
   output logic [5:0]               rand_o,
   output logic [19:0]              score_bcd_o,
   output logic                     show_replay_o
);

   localparam int DIV_W  = $clog2(TICK_DIV);
   localparam int PASS_W = $clog2(PASSES_PER_LEVEL + 1);
   localparam int DY_W   = $clog2(DYING_TICKS + 1);

   game_state_t       state_q;
   logic [DIV_W-1:0]  div_q;
   logic [PASS_W-1:0] pass_q;
   logic [DY_W-1:0]   dying_q;
   logic [10:0]       speed_q;
   logic [1:0]        anim_q;
   logic [5:0]        lfsr_q;
   logic              sync1_q, sync2_q, sync3_q;
   logic              press;
   logic              counting;
   logic              tick;
   logic              motion_tick;
   logic              score_clr;

   assign press       = sync2_q & ~sync3_q;
   assign counting    = (state_q == RUN) || (state_q == DYING);
   assign tick        = counting && (div_q == DIV_W'(TICK_DIV - 1));
   assign motion_tick = tick && (state_q == RUN) && !collision_i;
   assign score_clr   = (state_q == RESTART);

   // Bring the raw button into clk_sys and keep one extra stage for edge detect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Game FSM together with the divider, speed schedule, phase and LFSR.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         pass_q  <= '0;
         dying_q <= '0;
         speed_q <= 11'(SPEED_INIT);
         anim_q  <= '0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         if (counting) begin
            div_q <= tick ? '0 : div_q + 1'b1;
         end else begin
            div_q <= '0;
         end

         case (state_q)
            IDLE: begin
               lfsr_q <= lfsr_next(lfsr_q);
               if (press) state_q <= RESTART;
            end
            RESTART: begin
               speed_q <= 11'(SPEED_INIT);
               pass_q  <= '0;
               anim_q  <= '0;
               state_q <= RUN;
            end
            RUN: begin
               if (collision_i) begin
                  state_q <= DYING;
                  dying_q <= DY_W'(DYING_TICKS - 1);
               end else if (motion_tick) begin
                  anim_q <= anim_q + 2'd1;
                  lfsr_q <= lfsr_next(lfsr_q);
                  if (|wrap_i) begin
                     if (pass_q == PASS_W'(PASSES_PER_LEVEL - 1)) begin
                        pass_q <= '0;
                        if (speed_q < 11'(SPEED_MAX)) speed_q <= speed_q + 11'd1;
                     end else begin
                        pass_q <= pass_q + 1'b1;
                     end
                  end
               end
            end
            DYING: begin
               if (tick) begin
                  if (dying_q == '0) state_q <= OVER;
                  else               dying_q <= dying_q - 1'b1;
               end
            end
            OVER: begin
               if (press) state_q <= RESTART;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   dino_bcd_counter u_score (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (score_clr),
      .inc     (motion_tick),
      .bcd_o   (score_bcd_o)
   );

   assign state_o       = state_q;
   assign motion_tick_o = motion_tick;
   assign speed_o       = speed_q;
   assign reload_o      = (state_q == RESTART);
   assign anim_phase_o  = anim_q;
   assign rand_o        = lfsr_q;
   assign show_replay_o = (state_q == OVER);

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Scoreboard bench for dino_game_ctrl with a fast divider and short schedule.
module tb_dino_game_ctrl;
   import dino_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        collision_i = 1'b0;
   logic [3:0]  wrap_i = 4'b0000;
   logic        btn_i = 1'b0;
   logic [2:0]  state_o;
   logic        motion_tick_o;
   logic [10:0] speed_o;
   logic        reload_o;
   logic [1:0]  anim_phase_o;
   logic [5:0]  rand_o;
   logic [19:0] score_bcd_o;
   logic        show_replay_o;

   always #5 clk = ~clk;

   dino_game_ctrl #(
      .TICK_DIV         (4),
      .SPEED_INIT       (1),
      .SPEED_MAX        (3),
      .PASSES_PER_LEVEL (3),
      .DYING_TICKS      (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .collision_i   (collision_i),
      .wrap_i        (wrap_i),
      .btn_i         (btn_i),
      .state_o       (state_o),
      .motion_tick_o (motion_tick_o),
      .speed_o       (speed_o),
      .reload_o      (reload_o),
      .anim_phase_o  (anim_phase_o),
      .rand_o        (rand_o),
      .score_bcd_o   (score_bcd_o),
      .show_replay_o (show_replay_o)
   );

   typedef struct packed {
      logic [19:0] score;
      logic [1:0]  anim;
      logic [10:0] speed;
      logic [5:0]  rnd;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          m_score, m_anim, m_speed, m_pass;
   logic [5:0]  m_rand;

   function automatic logic [5:0] lfsr_ref(input logic [5:0] r);
      logic [5:0] n;
      n = {r[4:0], r[5] ^ r[4]};
      return n;
   endfunction

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int d;
      r = '0;
      d = v;
      for (int i = 0; i < 5; i++) begin
         r[i*4 +: 4] = 4'(d % 10);
         d = d / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_restart();
      m_score = 0;
      m_anim  = 0;
      m_speed = 1;
      m_pass  = 0;
   endtask

   // Expected post-tick outputs for the next n motion ticks.
   task automatic push_ticks(input int n, input bit wrap);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         m_score = (m_score < 99999) ? m_score + 1 : 99999;
         m_anim  = (m_anim + 1) % 4;
         m_rand  = lfsr_ref(m_rand);
         if (wrap) begin
            m_pass++;
            if (m_pass == 3) begin
               m_pass = 0;
               if (m_speed < 3) m_speed++;
            end
         end
         e.score = to_bcd(m_score);
         e.anim  = 2'(m_anim);
         e.speed = 11'(m_speed);
         e.rnd   = m_rand;
         exp_q.push_back(e);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every motion tick seen must match the next expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && motion_tick_o) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL tick_unexpected: got motion tick, expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("tick_score", 32'(score_bcd_o), 32'(e.score));
               chk("tick_anim", 32'(anim_phase_o), 32'(e.anim));
               chk("tick_speed", 32'(speed_o), 32'(e.speed));
               chk("tick_rand", 32'(rand_o), 32'(e.rnd));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of run");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] r;

      // 1. reset values, then start press with a held button
      step(2);
      chk("rst_state", 32'(state_o), 32'(IDLE));
      chk("rst_tick", 32'(motion_tick_o), 32'd0);
      chk("rst_speed", 32'(speed_o), 32'd1);
      chk("rst_reload", 32'(reload_o), 32'd0);
      chk("rst_anim", 32'(anim_phase_o), 32'd0);
      chk("rst_rand", 32'(rand_o), 32'h2b);
      chk("rst_score", 32'(score_bcd_o), 32'd0);
      chk("rst_replay", 32'(show_replay_o), 32'd0);
      reset_n = 1'b1;
      step(5);
      r = LFSR_SEED;
      for (int i = 0; i < 5; i++) r = lfsr_ref(r);
      chk("idle_rand", 32'(rand_o), 32'(r));

      model_restart();
      m_rand = LFSR_SEED;
      for (int i = 0; i < 8; i++) m_rand = lfsr_ref(m_rand);
      push_ticks(10, 1'b0);

      btn_i = 1'b1;
      step(1);
      chk("press_k0", 32'(state_o), 32'(IDLE));
      step(1);
      chk("press_k1", 32'(state_o), 32'(IDLE));
      step(1);
      chk("press_k2_state", 32'(state_o), 32'(RESTART));
      chk("press_k2_reload", 32'(reload_o), 32'd1);
      step(1);
      chk("press_k3_state", 32'(state_o), 32'(RUN));
      chk("press_k3_reload", 32'(reload_o), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("held_btn_state", 32'(state_o), 32'(RUN));
      end
      btn_i = 1'b0;

      // 2. forty RUN cycles -> ten ticks
      step(34);
      chk("run40_score", 32'(score_bcd_o), 32'h00010);
      chk("run40_anim", 32'(anim_phase_o), 32'd2);
      #2;
      chk("run40_queue", 32'(exp_q.size()), 32'd0);

      // 3. wrap on every tick -> speed schedule with saturation
      wrap_i = 4'b0001;
      push_ticks(9, 1'b1);
      step(36);
      chk("wrap_speed", 32'(speed_o), 32'd3);
      wrap_i = 4'b0000;
      #2;
      chk("wrap_queue", 32'(exp_q.size()), 32'd0);

      // 4. collision in a tick cycle, dying freeze, over, held and fresh press
      step(3);
      collision_i = 1'b1;
      #1;
      chk("coll_tick_suppressed", 32'(motion_tick_o), 32'd0);
      step(1);
      chk("coll_state", 32'(state_o), 32'(DYING));
      chk("coll_score", 32'(score_bcd_o), 32'h00019);
      collision_i = 1'b0;
      btn_i = 1'b1;
      step(7);
      chk("dying_7", 32'(state_o), 32'(DYING));
      step(1);
      chk("over_state", 32'(state_o), 32'(OVER));
      chk("over_replay", 32'(show_replay_o), 32'd1);
      step(3);
      chk("over_held_btn", 32'(state_o), 32'(OVER));
      btn_i = 1'b0;
      step(3);
      model_restart();
      push_ticks(100, 1'b0);
      btn_i = 1'b1;
      step(2);
      chk("over_wait", 32'(state_o), 32'(OVER));
      step(1);
      chk("replay_restart", 32'(state_o), 32'(RESTART));
      chk("replay_reload", 32'(reload_o), 32'd1);
      chk("replay_overlay_off", 32'(show_replay_o), 32'd0);
      btn_i = 1'b0;
      step(1);
      chk("replay_run", 32'(state_o), 32'(RUN));
      chk("replay_score", 32'(score_bcd_o), 32'd0);
      chk("replay_speed", 32'(speed_o), 32'd1);
      chk("replay_anim", 32'(anim_phase_o), 32'd0);

      // 5. carry 00099 -> 00100, then saturation at 99999
      step(400);
      chk("carry_score", 32'(score_bcd_o), 32'h00100);
      #2;
      chk("carry_queue", 32'(exp_q.size()), 32'd0);
      force dut.u_score.bcd_q = 20'h99998;
      #1;
      release dut.u_score.bcd_q;
      m_score = 99998;
      push_ticks(3, 1'b0);
      step(12);
      chk("sat_score", 32'(score_bcd_o), 32'h99999);

      // 6. asynchronous reset mid-RUN with speed 3 and score 57
      collision_i = 1'b1;
      step(1);
      chk("p6_dying", 32'(state_o), 32'(DYING));
      collision_i = 1'b0;
      step(9);
      chk("p6_over", 32'(state_o), 32'(OVER));
      btn_i = 1'b1;
      step(3);
      chk("p6_restart", 32'(state_o), 32'(RESTART));
      btn_i = 1'b0;
      model_restart();
      wrap_i = 4'b0001;
      push_ticks(57, 1'b1);
      step(1);
      step(228);
      chk("p6_score", 32'(score_bcd_o), 32'h00057);
      chk("p6_speed", 32'(speed_o), 32'd3);
      step(3);
      chk("p6_tick_pending", 32'(motion_tick_o), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_state", 32'(state_o), 32'(IDLE));
      chk("arst_tick", 32'(motion_tick_o), 32'd0);
      chk("arst_speed", 32'(speed_o), 32'd1);
      chk("arst_reload", 32'(reload_o), 32'd0);
      chk("arst_anim", 32'(anim_phase_o), 32'd0);
      chk("arst_rand", 32'(rand_o), 32'h2b);
      chk("arst_score", 32'(score_bcd_o), 32'd0);
      chk("arst_replay", 32'(show_replay_o), 32'd0);
      wrap_i = 4'b0000;
      step(2);
      chk("arst_held_state", 32'(state_o), 32'(IDLE));
      reset_n = 1'b1;
      #1;
      chk("rel_state", 32'(state_o), 32'(IDLE));
      chk("rel_rand", 32'(rand_o), 32'h2b);
      step(1);
      chk("rel_rand_step", 32'(rand_o), 32'(lfsr_ref(LFSR_SEED)));
      chk("end_queue", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
